grid_scan: RTL
==============

GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 Parameter ROW_DWELL, default 1000: cycles each row is driven; legal range 1..65535.
REQ-002 Parameter BLANK_CYC, default 16: blanking cycles after row 15; legal range 1..255.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port grid  input  256: 16x16 generation; row r = grid[255-16r -: 16]; within a row, bit 15 is column 0.
REQ-006 Port grid_valid  input  1: grid holds a new generation.
REQ-007 Port grid_ready  output  1: block can accept a grid; a transfer occurs when grid_valid and grid_ready are both high on a clk edge.
REQ-008 Port row_sel  output  16: one-hot row drive, bit r = row r; all zero when idle or blanking.
REQ-009 Port col_data  output  16: column data for the driven row; zero whenever row_sel is zero.
REQ-010 Port frame_done  output  1: one-cycle pulse at end of each displayed frame.
REQ-011 Port pop_count  output  9: live-cell count of the last completed frame, 0..256.
REQ-012 Port still  output  1: last promoted generation equals the one it replaced.
REQ-013 Port gen_count  output  16: number of generations promoted since reset.

Function
REQ-014 The block SHALL hold two 256-bit registers, active (being scanned) and pending, plus a pending_valid flag.
REQ-015 The state machine SHALL have exactly three states: IDLE, SCAN, BLANK.
REQ-016 IDLE: grid_ready=1, row_sel=0; a transfer loads active, increments gen_count and enters SCAN at row 0 on the next cycle.
REQ-017 SCAN: row_sel has only bit r set; col_data = active row r; each row is held exactly ROW_DWELL cycles, then r advances by one.
REQ-018 After row 15's dwell, SCAN SHALL go to BLANK for exactly BLANK_CYC cycles with row_sel=0 and col_data=0.
REQ-019 Frame length SHALL be exactly 16*ROW_DWELL+BLANK_CYC cycles from the first SCAN cycle of row 0 to the next first SCAN cycle of row 0.
REQ-020 Outside IDLE, grid_ready SHALL equal !pending_valid; a transfer loads pending and sets pending_valid.
REQ-021 On the first SCAN cycle of each row, popcount(active row r) SHALL be added to a 9-bit accumulator, which clears at frame start.
REQ-022 On the last BLANK cycle, frame_done SHALL pulse for one cycle and pop_count SHALL load the accumulator total.
REQ-023 On the last BLANK cycle, if pending_valid=1, the block SHALL perform these actions:
- promote pending to active;
- set still = (pending == active);
- increment gen_count;
- clear pending_valid.
REQ-024 On the last BLANK cycle, if pending_valid=0 and a transfer occurs in that cycle, the block SHALL promote the incoming grid directly and SHALL leave pending_valid at 0.
REQ-025 On the last BLANK cycle, if no new grid is available, the block SHALL rescan the same active grid; still, gen_count and active SHALL be unchanged.
REQ-026 The block SHALL return to SCAN row 0 after BLANK and SHALL never re-enter IDLE except by reset.
REQ-027 gen_count SHALL wrap from 65535 to 0; pop_count SHALL represent 256 exactly.
REQ-028 A grid offered while pending_valid=1 SHALL be stalled, not dropped; pending SHALL be overwritten only by a completed transfer.
REQ-029 A promotion SHALL take effect only at a frame boundary; the active grid SHALL never change mid-frame.

Reset
REQ-030 While reset=0, the block SHALL hold the following values:
- state=IDLE;
- active, pending, accumulator = 0;
- pending_valid=0;
- row_sel=0, col_data=0, frame_done=0, pop_count=0, still=0, gen_count=0;
- grid_ready=0.
REQ-031 The block SHALL abandon a frame in progress on reset and, after release, SHALL restart from IDLE with grid_ready=1 on the first clock edge.

Verification (ROW_DWELL=4, BLANK_CYC=2, frame = 66 cycles)
REQ-032 First grid: transfer grid with rows 1-3 = 0x2000, all others 0 -> one cycle later row_sel=0x0001, col_data=0x0000 for 4 cycles; while row_sel=0x0002, col_data=0x2000; frame_done after 66 cycles; pop_count=3; gen_count=1.
REQ-033 Refresh: no further grid_valid -> the identical 66-cycle frame repeats, frame_done pulses every 66 cycles, gen_count stays 1, still stays 0.
REQ-034 Back-pressure: offer grid A mid-frame and grid B right after -> A accepted; grid_ready=0 until the frame boundary; B held; A shown next frame, B the frame after; gen_count +2.
REQ-035 Still life: promote a grid equal to the active one -> still=1 after that frame boundary; a different grid next frame -> still=0.
REQ-036 Boundary bypass: pending empty and grid_valid asserted exactly on the last BLANK cycle -> grid shown starting the next cycle; pending_valid stays 0.
REQ-037 Reset mid-row: reset=0 during row 7 -> row_sel=0 and all outputs zero immediately; after release, grid_ready=1 and the next grid starts at row 0.

Source files
------------

// File: rtl/grid_scan.sv
// 16x16 LED-grid row scanner: double-buffered generations, fixed-rate row multiplexing,
// per-frame live-cell count and still-life detection.
module grid_scan #(
    parameter int unsigned ROW_DWELL = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] grid,
    input  logic         grid_valid,
    output logic         grid_ready,
    output logic [15:0]  row_sel,
    output logic [15:0]  col_data,
    output logic         frame_done,
    output logic [8:0]   pop_count,
    output logic         still,
    output logic [15:0]  gen_count
);

    localparam int unsigned GRID_W  = 256;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned LINE_W  = 16;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned BLANK_W = 8;
    localparam int unsigned POP_W   = 9;
    localparam int unsigned GEN_W   = 16;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(15);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } state_e;

    // Row r lives at grid[255-16r -: 16], i.e. 16*(15-r) bits above the LSB.
    function automatic logic [LINE_W-1:0] row_of(input logic [GRID_W-1:0] g,
                                                 input logic [ROW_W-1:0]  r);
        return LINE_W'(g >> {~r, 4'b0000});
    endfunction

    function automatic logic [4:0] ones16(input logic [LINE_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [BLANK_W-1:0]  blank_q, blank_d;
    logic [GRID_W-1:0]   active_q, active_d;
    logic [GRID_W-1:0]   pending_q, pending_d;
    logic                pending_valid_q, pending_valid_d;
    logic [POP_W-1:0]    acc_q, acc_d;
    logic [POP_W-1:0]    pop_count_q, pop_count_d;
    logic                still_q, still_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic                frame_done_q, frame_done_d;
    logic [LINE_W-1:0]   row_sel_q, row_sel_d;
    logic [LINE_W-1:0]   col_data_q, col_data_d;
    logic                grid_ready_q, grid_ready_d;

    logic xfer_c;
    logic last_blank_c;

    assign xfer_c       = grid_valid && grid_ready_q;
    assign last_blank_c = (state_q == BLANK) && (blank_q == BLANK_LAST);

    // Next-state, buffer management and registered-output precompute.
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        dwell_d         = dwell_q;
        blank_d         = blank_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        acc_d           = acc_q;
        pop_count_d     = pop_count_q;
        still_d         = still_q;
        gen_count_d     = gen_count_q;
        frame_done_d    = 1'b0;
        row_sel_d       = '0;
        col_data_d      = '0;
        grid_ready_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    active_d    = grid;
                    gen_count_d = gen_count_q + GEN_W'(1);
                    state_d     = SCAN;
                    row_d       = '0;
                    dwell_d     = '0;
                end
            end
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = BLANK;
                        blank_d = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            BLANK: begin
                if (last_blank_c) begin
                    state_d = SCAN;
                    row_d   = '0;
                    dwell_d = '0;
                    // Frame boundary: a buffered grid wins; otherwise an incoming one bypasses pending.
                    if (pending_valid_q) begin
                        active_d        = pending_q;
                        still_d         = (pending_q == active_q);
                        gen_count_d     = gen_count_q + GEN_W'(1);
                        pending_valid_d = 1'b0;
                    end else if (xfer_c) begin
                        active_d    = grid;
                        still_d     = (grid == active_q);
                        gen_count_d = gen_count_q + GEN_W'(1);
                    end
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer_c && (state_q != IDLE) && !last_blank_c) begin
            pending_d       = grid;
            pending_valid_d = 1'b1;
        end

        // Accumulate each row's live cells as the row is entered; row 0 restarts the sum.
        if ((state_d == SCAN) && (dwell_d == '0)) begin
            acc_d = ((row_d == '0) ? POP_W'(0) : acc_q) + POP_W'(ones16(row_of(active_d, row_d)));
        end

        if ((state_d == BLANK) && (blank_d == BLANK_LAST)) begin
            frame_done_d = 1'b1;
            pop_count_d  = acc_q;
        end

        if (state_d == SCAN) begin
            row_sel_d  = LINE_W'(LINE_W'(1) << row_d);
            col_data_d = row_of(active_d, row_d);
        end

        grid_ready_d = (state_d == IDLE) ? 1'b1 : !pending_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            dwell_q         <= '0;
            blank_q         <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            acc_q           <= '0;
            pop_count_q     <= '0;
            still_q         <= 1'b0;
            gen_count_q     <= '0;
            frame_done_q    <= 1'b0;
            row_sel_q       <= '0;
            col_data_q      <= '0;
            grid_ready_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            dwell_q         <= dwell_d;
            blank_q         <= blank_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            acc_q           <= acc_d;
            pop_count_q     <= pop_count_d;
            still_q         <= still_d;
            gen_count_q     <= gen_count_d;
            frame_done_q    <= frame_done_d;
            row_sel_q       <= row_sel_d;
            col_data_q      <= col_data_d;
            grid_ready_q    <= grid_ready_d;
        end
    end

    assign grid_ready = grid_ready_q;
    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign pop_count  = pop_count_q;
    assign still      = still_q;
    assign gen_count  = gen_count_q;

endmodule
